// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, centre-sampling bit FSM,
// and a valid/ack output register with framing-error and overrun pulses.
module uart_rx #(
    parameter int FREQ_CLKIN = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int BIT_CNT   = FREQ_CLKIN / BAUD_RATE;
    localparam int HALF_CNT  = BIT_CNT / 2;
    localparam int CNT_WIDTH = $clog2(BIT_CNT);

    localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(BIT_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF_CNT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic [1:0]           sync_q;
    logic                 rxd_s;
    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 byte_done;

    assign rxd_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = START;
            end
            // Re-check the start bit at its centre to reject short glitches.
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    shift_d[idx_q] = rxd_s;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            // A line held low after a bad stop bit must not look like new starts.
            BREAK: begin
                cnt_d = '0;
                if (rxd_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_ack;
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the baud-rate transmit path.
- Synchronises the asynchronous serial input and detects a start bit.
- Samples each bit at its centre using an internal bit-period counter derived from FREQ_CLKIN/BAUD_RATE.
- Presents the received byte on a valid/ack handshake to downstream logic, with framing-error and overrun flags.

Parameters:
- FREQ_CLKIN, 100_000_000, input clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud.
- (derived, not overridable) BIT_CNT = FREQ_CLKIN / BAUD_RATE (integer division); HALF_CNT = BIT_CNT / 2; CNT_WIDTH = $clog2(BIT_CNT).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rxd  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  high while rx_data holds an unacknowledged byte.
- rx_ack  input  1  consumer acknowledge; clears rx_valid.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: new byte completed while rx_valid=1 and no ack in that cycle.

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE; bit counter and bit index = 0.
- rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_overrun=0.
- Both synchroniser flops = 1.
- Reset mid-frame abandons the frame; nothing is delivered.

Synchroniser:
- Two-flop chain on rxd; rxd_s is the second flop.
- All decisions use rxd_s, giving 2 cycles of input latency.

Bit counter:
- CNT_WIDTH bits; restarts from 0 on every state transition.
- Compares against HALF_CNT-1 or BIT_CNT-1; it never wraps in normal operation.

FSM:
- IDLE: rxd_s==0 -> START, cnt=0.
- START: at cnt==HALF_CNT-1, re-sample rxd_s.
  - rxd_s==0: -> DATA, cnt=0, idx=0.
  - rxd_s==1: glitch, -> IDLE, no flags.
- DATA: at cnt==BIT_CNT-1, shift rxd_s into the shift register LSB-first (bit idx lands in position idx), cnt=0, idx++.
  - After idx==7 is sampled: -> STOP.
- STOP: at cnt==BIT_CNT-1, sample rxd_s.
  - rxd_s==1: load rx_data from the shift register, set rx_valid=1, -> IDLE.
  - rxd_s==0: pulse rx_frame_err for 1 cycle, leave rx_data/rx_valid unchanged, -> BREAK.
- BREAK: wait for rxd_s==1, then -> IDLE. This prevents a held-low line from being re-detected as repeated start bits.

Latency:
- rx_valid rises on the clock after the stop-bit centre sample.
- Stop-bit centre = HALF_CNT + 9*BIT_CNT cycles after the first cycle in which rxd_s==0.

Handshake:
- rx_ack && rx_valid clears rx_valid on the next edge.
- rx_ack while rx_valid=0 is ignored.
- rx_data is stable while rx_valid=1, except on overrun.

Simultaneous events:
- New byte completes in the same cycle as rx_ack: the new byte loads, rx_valid stays 1, no overrun.
- New byte completes while rx_valid=1 and rx_ack=0: rx_data is overwritten with the new byte, rx_valid stays 1, rx_overrun pulses 1 cycle.

Back-to-back frames:
- A start edge is accepted in the first cycle after the return to IDLE.
- No inter-frame gap is required beyond the stop bit.

Test Plan:
Bench uses FREQ_CLKIN=1_600_000, BAUD_RATE=100_000 (BIT_CNT=16, HALF_CNT=8).

- Send 0xA5 8N1, idle line before and after:
  - rx_data=8'hA5, rx_valid rises exactly 8+9*16=152 cycles after the first rxd_s==0 cycle.
  - rx_valid holds until rx_ack; clears the cycle after rx_ack=1.
- Send 0x00 then 0xFF back-to-back, acking each byte immediately:
  - Two rx_valid assertions with 0x00 then 0xFF; no rx_frame_err, no rx_overrun.
- Drive rxd low for 5 cycles only (glitch shorter than HALF_CNT):
  - FSM returns to IDLE; rx_valid, rx_frame_err and rx_overrun all remain 0.
- Send 0x3C with the stop bit forced low, then hold the line low for 40 cycles, then release high:
  - rx_frame_err pulses once, exactly 1 cycle.
  - rx_valid stays 0; no further start detected until the line goes high.
  - A following 0x81 frame is received correctly.
- Send 0x11 without ack, then 0x22 without ack:
  - rx_overrun pulses 1 cycle at the second completion; rx_data=8'h22, rx_valid=1.
  - Repeat with rx_ack asserted in the completion cycle: no overrun.
- Assert rst_n=0 for 1 cycle during data bit 4 of a frame:
  - All outputs return to reset values at that edge.
  - The remaining bits of that frame produce no rx_valid (a low tail bit may appear as a start, which must fail stop-bit or glitch checks).
  - The next full frame 0x5A is received correctly.
